// File: rtl/adc_serial_emulator_pkg.sv
// Shared constants and FSM encoding for the serial ADC emulator.
// ADC_DATA_W / ADC_LEAD_ZEROS are also used by the ADC controller.
package adc_serial_emulator_pkg;

  localparam int unsigned ADC_DATA_W     = 12;
  localparam int unsigned ADC_LEAD_ZEROS = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLead = 2'd1,
    StData = 2'd2,
    StTail = 2'd3
  } adc_emu_state_e;

endpackage

// File: rtl/adc_serial_emulator_sync_edge_detect.sv
// Synchronizer chain plus edge register for an idle-high control input.
// Produces one-cycle rise/fall strobes, SYNC_STAGES cycles after the input moves.
module adc_serial_emulator_sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Shift the raw input through the chain; flops reset to the idle (high) level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {SYNC_STAGES{1'b1}};
      edge_q <= 1'b1;
    end else begin
      sync_q[0] <= sig_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Strobes compare the synchronized level with its one-cycle-old copy.
  always_comb begin
    rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;
    fall_o = ~sync_q[SYNC_STAGES-1] & edge_q;
  end

endmodule

// File: rtl/adc_serial_emulator.sv
// Serial ADC emulator: answers the ADC controller's cs_n/sclk with a
// LEAD_ZEROS + DATA_W bit frame, MSB first, changing on sclk falling edges.
// Build option: ADC_EMU_RAMP_EN replaces sample_in with an internal ramp that
// advances by RAMP_STEP per completed frame (RAMP_STEP exists only then).
module adc_serial_emulator
  import adc_serial_emulator_pkg::*;
#(
  parameter int unsigned DATA_W      = ADC_DATA_W,
  parameter int unsigned LEAD_ZEROS  = ADC_LEAD_ZEROS,
  parameter int unsigned SYNC_STAGES = 2
`ifdef ADC_EMU_RAMP_EN
  ,
  parameter int unsigned RAMP_STEP   = 1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic [DATA_W-1:0] sample_in,
  output logic              serial_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [DATA_W-1:0] last_sample
);

  localparam int unsigned FRAME_BITS = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LeadLast  = CNT_W'(LEAD_ZEROS - 1);
  localparam logic [CNT_W-1:0] FrameLast = CNT_W'(FRAME_BITS - 1);

  logic sclk_fall, sclk_rise, cs_fall, cs_rise;
  logic unused_sclk_rise;

  adc_serial_emulator_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sclk (
    .clk_i  (clk),
    .reset_i(reset),
    .sig_i  (sclk_in),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  adc_serial_emulator_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cs (
    .clk_i  (clk),
    .reset_i(reset),
    .sig_i  (cs_n_in),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  assign unused_sclk_rise = sclk_rise;

  adc_emu_state_e    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] frame_src;
  logic              frame_end;

  // Last data fall of an uninterrupted frame.
  assign frame_end = (state_q == StData) && !cs_rise && sclk_fall && (cnt_q == FrameLast);

`ifdef ADC_EMU_RAMP_EN
  logic [DATA_W-1:0] ramp_q;

  // Ramp advances only on completed frames; aborts leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_q <= '0;
    end else if (frame_end) begin
      ramp_q <= ramp_q + DATA_W'(RAMP_STEP);
    end
  end

  assign frame_src = ramp_q;
`else
  assign frame_src = sample_in;
`endif

  // Frame FSM. The shift register rotates rather than discarding bits, so after
  // the final rotation it holds the original sample again for last_sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      serial_data <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      last_sample <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state_q)
        StIdle: begin
          serial_data <= 1'b0;
          // cs fall wins over a coincident sclk fall: that edge is not counted.
          if (cs_fall) begin
            shreg_q <= frame_src;
            cnt_q   <= '0;
            busy    <= 1'b1;
            if (LEAD_ZEROS == 0) begin
              serial_data <= frame_src[DATA_W-1];
              state_q     <= StData;
            end else begin
              state_q <= StLead;
            end
          end
        end
        StLead, StData: begin
          if (cs_rise) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            serial_data <= 1'b0;
            busy        <= 1'b0;
            frame_abort <= 1'b1;
          end else if (sclk_fall) begin
            cnt_q <= cnt_q + 1'b1;
            if (state_q == StLead) begin
              if (cnt_q == LeadLast) begin
                serial_data <= shreg_q[DATA_W-1];
                state_q     <= StData;
              end
            end else begin
              shreg_q <= {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
              if (cnt_q == FrameLast) begin
                serial_data <= 1'b0;
                last_sample <= {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                frame_done  <= 1'b1;
                state_q     <= StTail;
              end else begin
                serial_data <= shreg_q[DATA_W-2];
              end
            end
          end
        end
        StTail: begin
          serial_data <= 1'b0;
          if (cs_rise) begin
            busy    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_emulator.sv
// Bench for adc_serial_emulator: an event-level model (frame bit index = number
// of counted sclk falls since cs fall) checked against the DUT every cycle,
// plus directed frames with literal expected read-back values.
module tb_adc_serial_emulator;

  localparam int unsigned DW = 12;
  localparam int unsigned LZ = 4;
  localparam int unsigned SS = 2;
  localparam int FB = 16;

  logic          clk = 1'b0;
  logic          reset, sclk_in, cs_n_in;
  logic [DW-1:0] sample_in;
  logic          serial_data, busy, frame_done, frame_abort;
  logic [DW-1:0] last_sample;

  adc_serial_emulator dut (
    .clk        (clk),
    .reset      (reset),
    .sclk_in    (sclk_in),
    .cs_n_in    (cs_n_in),
    .sample_in  (sample_in),
    .serial_data(serial_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .last_sample(last_sample)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [SS+1:0] h_sclk, h_cs;  // index 0 = newest sample
  bit            m_in_frame, m_done, m_abort, m_sd, m_busy;
  int            m_n;
  logic [DW-1:0] m_val, m_last, m_ramp;

  function automatic logic frame_bit(input logic [DW-1:0] v, input int n);
    if (n < int'(LZ)) return 1'b0;
    return v[DW-1-(n-int'(LZ))];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      m_done  = 1'b0;
      m_abort = 1'b0;
      if (reset) begin
        h_sclk     = '1;
        h_cs       = '1;
        m_in_frame = 1'b0;
        m_n        = 0;
        m_val      = '0;
        m_last     = '0;
        m_ramp     = '0;
      end else begin
        h_sclk = {h_sclk[SS:0], sclk_in};
        h_cs   = {h_cs[SS:0], cs_n_in};
        // Events become visible to the frame logic SYNC_STAGES samples late.
        if (h_cs[SS+1] && !h_cs[SS]) begin
          m_in_frame = 1'b1;
          m_n        = 0;
`ifdef ADC_EMU_RAMP_EN
          m_val = m_ramp;
`else
          m_val = sample_in;
`endif
        end else if (!h_cs[SS+1] && h_cs[SS]) begin
          if (m_in_frame && m_n < FB) m_abort = 1'b1;
          m_in_frame = 1'b0;
        end else if (h_sclk[SS+1] && !h_sclk[SS] && m_in_frame && m_n < FB) begin
          m_n++;
          if (m_n == FB) begin
            m_done = 1'b1;
            m_last = m_val;
            m_ramp = m_ramp + 1'b1;
          end
        end
      end
      m_busy = m_in_frame;
      m_sd   = (m_in_frame && m_n < FB) ? frame_bit(m_val, m_n) : 1'b0;
    end
  end

  // Per-cycle comparison against the model, plus pulse counters.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checks++;
        if (serial_data !== m_sd || busy !== m_busy || frame_done !== m_done ||
            frame_abort !== m_abort || last_sample !== m_last) begin
          errors++;
          $display("FAIL cycle_model t=%0t actual sd=%b busy=%b done=%b abort=%b last=%h required sd=%b busy=%b done=%b abort=%b last=%h",
                   $time, serial_data, busy, frame_done, frame_abort, last_sample,
                   m_sd, m_busy, m_done, m_abort, m_last);
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input logic [DW-1:0] s, input bit coincident);
    sample_in = s;
    if (coincident) begin
      sclk_in = 1'b0;
      cs_n_in = 1'b0;
      tick(4);
    end else begin
      sclk_in = 1'b0;  // falls while cs_n high: must be ignored
      tick(4);
      cs_n_in = 1'b0;
      tick(4);
    end
  endtask

  // Controller reads serial_data just before each sclk rise.
  task automatic clock_bits(input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      if (i < FB) rd = {rd[14:0], serial_data};
      sclk_in = 1'b1;
      tick(4);
      sclk_in = 1'b0;
      tick(4);
    end
  endtask

  task automatic end_frame();
    sclk_in = 1'b1;
    tick(4);
    cs_n_in = 1'b1;
    tick(8);
  endtask

  logic [15:0] rd;
  int          done_before;

  initial begin
    reset     = 1'b1;
    sclk_in   = 1'b1;
    cs_n_in   = 1'b1;
    sample_in = '0;
    tick(3);
    reset  = 1'b0;
    cmp_en = 1'b1;
    check("reset_serial_data", 32'(serial_data), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_frame_abort", 32'(frame_abort), 32'h0);
    check("reset_last_sample", 32'(last_sample), 32'h0);
    tick(4);

`ifndef ADC_EMU_RAMP_EN
    // Plain frame.
    start_frame(12'hA5C, 1'b0);
    clock_bits(16, rd);
    end_frame();
    check("a5c_bits", 32'(rd), 32'h0A5C);
    check("a5c_done_count", 32'(done_cnt), 32'd1);
    check("a5c_last_sample", 32'(last_sample), 32'hA5C);
    check("a5c_model_last", 32'(m_last), 32'hA5C);
    check("a5c_busy_after", 32'(busy), 32'h0);

    // Abort after 9 counted falls.
    start_frame(12'h3C3, 1'b0);
    clock_bits(9, rd);
    cs_n_in = 1'b1;
    tick(SS + 1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_serial_data", 32'(serial_data), 32'h0);
    tick(1);
    check("abort_count", 32'(abort_cnt), 32'd1);
    check("abort_last_kept", 32'(last_sample), 32'hA5C);
    check("abort_no_done", 32'(done_cnt), 32'd1);
    sclk_in = 1'b1;
    tick(8);

    // Reset in the middle of a frame.
    start_frame(12'h777, 1'b0);
    clock_bits(7, rd);
    reset   = 1'b1;
    cs_n_in = 1'b1;
    sclk_in = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_serial_data", 32'(serial_data), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(frame_done), 32'h0);
    check("rst_mid_abort", 32'(frame_abort), 32'h0);
    check("rst_mid_last", 32'(last_sample), 32'h0);
    tick(6);
    start_frame(12'h001, 1'b0);
    clock_bits(16, rd);
    end_frame();
    check("post_rst_bits", 32'(rd), 32'h0001);
    check("post_rst_last", 32'(last_sample), 32'h001);

    // Extra sclk periods after the frame while cs stays low.
    done_before = done_cnt;
    start_frame(12'h5A3, 1'b0);
    clock_bits(36, rd);
    check("tail_bits", 32'(rd), 32'h05A3);
    check("tail_done_once", 32'(done_cnt - done_before), 32'd1);
    check("tail_busy_held", 32'(busy), 32'h1);
    check("tail_serial_zero", 32'(serial_data), 32'h0);
    end_frame();
    check("tail_busy_clear", 32'(busy), 32'h0);

    // cs fall coincident with an sclk fall.
    start_frame(12'hFFF, 1'b1);
    clock_bits(16, rd);
    end_frame();
    check("coinc_bits", 32'(rd), 32'h0FFF);
    check("coinc_last", 32'(last_sample), 32'hFFF);
`else
    // Ramp source: 0, 1, 2, aborted frame, then 3.
    for (int f = 0; f < 3; f++) begin
      start_frame(12'hABC, 1'b0);
      clock_bits(16, rd);
      end_frame();
      check("ramp_bits", 32'(rd), 32'(f));
    end
    start_frame(12'hABC, 1'b0);
    clock_bits(9, rd);
    end_frame();
    check("ramp_abort_count", 32'(abort_cnt), 32'd1);
    start_frame(12'hABC, 1'b0);
    clock_bits(16, rd);
    end_frame();
    check("ramp_after_abort", 32'(rd), 32'h3);
    check("ramp_last", 32'(last_sample), 32'h3);
    check("ramp_done_count", 32'(done_cnt), 32'd4);
`endif

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_serial_emulator.md
Name: adc_serial_emulator

Overview:
- Synthesizable responder for the serial ADC readout link: emulates the 12-bit serial ADC that the ADC controller reads through chip-select, ADC clock and serial data.
- Lets the ADC controller, sensor timing and data path run in on-board loopback and in simulation without the analog front end fitted.
- Sits in the 20 MHz domain. Takes the controller's internal cs/ADC-clock nets and drives a serial_data line in place of the real ADC pin.

Parameters:
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 4, leading zero bits per frame before the MSB.
- SYNC_STAGES, 2, synchronizer depth on sclk_in and cs_n_in (minimum 1).
- RAMP_STEP, 1, ramp increment per completed frame (used only with the optional feature).

Ports:
- clk, input, 1, 20 MHz system clock.
- reset, input, 1, synchronous, active-high.
- sclk_in, input, 1, ADC serial clock from the controller; idle high.
- cs_n_in, input, 1, chip select from the controller; active low.
- sample_in, input, DATA_W, sample value to transmit; latched at the start of each frame.
- serial_data, output, 1, emulated ADC data out.
- busy, output, 1, high while a frame is in progress.
- frame_done, output, 1, one-cycle pulse when a full frame has been sent.
- frame_abort, output, 1, one-cycle pulse when cs deasserts mid-frame.
- last_sample, output, DATA_W, value sent in the most recent completed frame.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: serial_data=0, busy=0, frame_done=0, frame_abort=0, last_sample=0, FSM=IDLE, bit counter=0, shift register=0. Synchronizer flops reset to idle levels (sclk=1, cs_n=1).
- Input conditioning:
  - sclk_in and cs_n_in each pass through a SYNC_STAGES flop chain, then one extra register for edge detection.
  - Edge events are one-cycle strobes.
  - Event-to-output latency is SYNC_STAGES+1 clk cycles.
  - Legal sclk_in high and low phases are each ≥ SYNC_STAGES+2 clk cycles. Faster clocks are out of spec and behaviour is undefined.
- Frame: LEAD_ZEROS+DATA_W bits, 16 by default. Leading zeros first, then sample bits MSB first. Output changes on sclk falling edges; the controller samples on rising edges.
- FSM states: IDLE, LEAD, DATA, TAIL.
  - IDLE: serial_data=0. On cs falling: load shift register with sample_in (or the ramp, see Optional Feature), bit counter=0, busy=1, go to LEAD. serial_data drives leading zero 0.
  - LEAD: each sclk falling edge increments the counter. When the counter reaches LEAD_ZEROS, serial_data=shreg[MSB], go to DATA. Otherwise serial_data stays 0.
  - DATA: each sclk falling edge shifts left by one and presents the next bit. After DATA_W bits have each been presented for one full sclk period, the next falling edge drives serial_data=0 and goes to TAIL. In the same cycle: last_sample is updated and frame_done pulses.
  - TAIL: serial_data=0. Extra sclk edges are ignored. On cs rising: busy=0, go to IDLE.
- cs rising in LEAD or DATA: go to IDLE on the event cycle, serial_data=0, busy=0, frame_abort pulses, last_sample unchanged.
- cs falling and an sclk falling edge on the same cycle: the cs event wins. The frame starts and that sclk edge is not counted.
- cs falling while not in IDLE: cannot occur without an intervening rise, which is handled first.
- sclk edges while cs_n is high: ignored.
- Reset mid-frame: immediate return to the reset state. No frame_done or frame_abort pulse.

Optional Feature:
- Macro: ADC_EMU_RAMP_EN.
- With the macro defined:
  - An internal DATA_W-bit ramp register (reset 0) replaces sample_in as the frame source.
  - The ramp advances by RAMP_STEP on each frame_done and wraps modulo 2^DATA_W.
  - Aborted frames do not advance the ramp.
  - sample_in is ignored.
- Without the macro: sample_in is latched at cs fall and no ramp logic exists.

Decomposition:
- Shared package holds:
  - ADC_DATA_W=12 and ADC_LEAD_ZEROS=4 constants, shared with the ADC controller.
  - FSM state encoding constants (IDLE, LEAD, DATA, TAIL).
- One natural sub-module: sync_edge_detect. It is the SYNC_STAGES chain plus edge register, outputs rise/fall strobes, and is instantiated for sclk and cs_n.

Test Plan:
- Frame with sample_in=12'hA5C: cs low, 16 sclk periods of 8 clk each → serial_data bits across rising edges read 0000_1010_0101_1100; frame_done pulses once; last_sample=12'hA5C.
- Abort: cs rises after 9 sclk falls → frame_abort pulses 1 cycle; busy=0 and serial_data=0 within SYNC_STAGES+1 clk; last_sample unchanged.
- Reset asserted at bit 7 of a frame → next cycle all outputs 0, FSM IDLE. The following full frame with 12'h001 reads back correctly.
- 20 extra sclk cycles after 16 bits with cs still low → serial_data stays 0, exactly one frame_done; cs rise → busy=0.
- cs fall coincident with sclk fall → the frame still carries 16 counted bits; sample 12'hFFF reads back 0000_1111_1111_1111.
- ADC_EMU_RAMP_EN, RAMP_STEP=1: 4097 frames → values 0,1,…,4095,0; an aborted frame inserted mid-sequence leaves the next value unchanged.
